// File: rtl/uart_pattern_sequencer.sv
// uart_pattern_sequencer: emits a repeating byte pattern to a UART transmitter
// over a four-phase req/ack handshake, paced by an internal tick.
// Optional build macro: SEQ_LFSR_EN selects an 8-bit Galois LFSR pattern
// (DATA_W must be 8) instead of the START_VAL..END_VAL ramp.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | load the first pattern value
// REQ      | raise tx_req for the current value
// WAIT_ACK | hold tx_req until the transmitter acknowledges
// WAIT_REL | wait for tx_ack to drop (four-phase completion)
// HOLD     | wait for auto_en or a button advance

module uart_pattern_sequencer #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       TICK_DIV  = 1160,
   parameter logic [DATA_W-1:0] START_VAL = 'h41,
   parameter logic [DATA_W-1:0] END_VAL   = 'h5A,
   parameter int unsigned       STEP      = 1,
   parameter int unsigned       DEB_BITS  = 17
) (
   input  logic              clk_raw,
   input  logic              rst_n,
   input  logic              next_raw,
   input  logic              auto_en,
   input  logic              tx_ack,
   output logic              tx_req,
   output logic [DATA_W-1:0] tx_data,
   output logic              tick,
   output logic [15:0]       sent_cnt
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, WAIT_REL, HOLD} state_e;

   localparam logic [11:0]     TICK_LAST = 12'(TICK_DIV - 1);
   localparam logic [DATA_W:0] STEP_W    = (DATA_W + 1)'(STEP);
`ifdef SEQ_LFSR_EN
   localparam logic [7:0]        SEED8 = (START_VAL[7:0] == 8'h00) ? 8'h01 : START_VAL[7:0];
   localparam logic [DATA_W-1:0] SEED  = DATA_W'(SEED8);
`else
   localparam logic [DATA_W-1:0] SEED  = START_VAL;
`endif

   logic [1:0]          rst_sync_q;
   logic                run;
   logic [11:0]         tick_cnt_q;
   logic [DEB_BITS-1:0] deb_cnt_q;
   logic                sync1_q, sync2_q, btn_q, adv_q;
   logic                tick_w, adv_pulse;
   state_e              state_q, state_d;
   logic                tx_req_q, tx_req_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d, nxt_val;
   logic [15:0]         sent_cnt_q, sent_cnt_d;
   logic                pend_q, pend_d;

   assign run       = rst_sync_q[1];
   assign tick_w    = run && (tick_cnt_q == TICK_LAST);
   assign adv_pulse = adv_q & tick_w;

   // Reset release is synchronised; assertion stays asynchronous.
   always_ff @(posedge clk_raw or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   // Free-running tick divider, held at zero until reset release is synchronised.
   always_ff @(posedge clk_raw or negedge rst_n) begin
      if (!rst_n)      tick_cnt_q <= '0;
      else if (!run)   tick_cnt_q <= '0;
      else if (tick_w) tick_cnt_q <= '0;
      else             tick_cnt_q <= tick_cnt_q + 12'd1;
   end

   // Button synchroniser, slow re-sampler and one-tick rising-edge advance pulse.
   always_ff @(posedge clk_raw or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         btn_q     <= 1'b0;
         adv_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q <= next_raw;
         sync2_q <= sync1_q;
         if (run) deb_cnt_q <= deb_cnt_q + 1'b1;
         if (run && (&deb_cnt_q)) begin
            btn_q <= sync2_q;
            if (sync2_q && !btn_q) adv_q <= 1'b1;
            else if (tick_w)       adv_q <= 1'b0;
         end else if (tick_w) begin
            adv_q <= 1'b0;
         end
      end
   end

   // Next pattern value.
`ifdef SEQ_LFSR_EN
   always_comb begin
      logic [7:0] cur8;
      cur8    = tx_data_q[7:0];
      nxt_val = DATA_W'({1'b0, cur8[7:1]} ^ (cur8[0] ? 8'hB8 : 8'h00));
   end
`else
   always_comb begin
      logic [DATA_W:0] sum;
      sum = {1'b0, tx_data_q} + STEP_W;
      if ((tx_data_q >= END_VAL) || sum[DATA_W]) nxt_val = START_VAL;
      else                                       nxt_val = sum[DATA_W-1:0];
   end
`endif

   // FSM and datapath registers.
   always_ff @(posedge clk_raw or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_req_q   <= 1'b0;
         tx_data_q  <= START_VAL;
         sent_cnt_q <= '0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         sent_cnt_q <= sent_cnt_d;
         pend_q     <= pend_d;
      end
   end

   // FSM next-state logic; only advances on tick cycles.
   always_comb begin
      state_d    = state_q;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      sent_cnt_d = sent_cnt_q;
      pend_d     = pend_q;
      if (tick_w) begin
         unique case (state_q)
            IDLE: begin
               tx_data_d = SEED;
               state_d   = REQ;
            end
            REQ: begin
               tx_req_d = 1'b1;
               state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (tx_ack) begin
                  tx_req_d   = 1'b0;
                  sent_cnt_d = sent_cnt_q + 16'd1;
                  state_d    = WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!tx_ack) state_d = HOLD;
            end
            HOLD: begin
               if (auto_en || pend_q || adv_pulse) begin
                  tx_data_d = nxt_val;
                  pend_d    = 1'b0;
                  state_d   = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
         // Presses outside HOLD are remembered once; extra presses collapse into it.
         if (adv_pulse && (state_q != HOLD)) pend_d = 1'b1;
      end
   end

   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign sent_cnt = sent_cnt_q;
   assign tick     = tick_w;

endmodule

// File: tb/tb_uart_pattern_sequencer.sv
// Scoreboard bench for uart_pattern_sequencer (ramp build, END_VAL=45 for a short wrap).
module tb_uart_pattern_sequencer;

   logic       clk_raw = 1'b0;
   logic       rst_n   = 1'b0;
   logic       next_raw = 1'b0;
   logic       auto_en  = 1'b0;
   logic       tx_ack   = 1'b0;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tick;
   logic [15:0] sent_cnt;

   int checks = 0;
   int passes = 0;
   int ack_mode = 0;          // 0 echo tx_req, 1 forced high, 2 forced low
   logic [7:0]  exp_data[$];
   logic [15:0] exp_cnt[$];

   uart_pattern_sequencer #(
      .DATA_W(8), .TICK_DIV(4), .START_VAL(8'h41), .END_VAL(8'h45),
      .STEP(1), .DEB_BITS(2)
   ) dut (
      .clk_raw(clk_raw), .rst_n(rst_n), .next_raw(next_raw), .auto_en(auto_en),
      .tx_ack(tx_ack), .tx_req(tx_req), .tx_data(tx_data), .tick(tick),
      .sent_cnt(sent_cnt)
   );

   always #5 clk_raw = ~clk_raw;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: got timeout/unexpected required expected event", name);
   endtask

   // Transmitter model: acknowledge follows the chosen mode.
   always @(negedge clk_raw) begin
      if (ack_mode == 1)      tx_ack = 1'b1;
      else if (ack_mode == 2) tx_ack = 1'b0;
      else                    tx_ack = tx_req;
   end

   // Monitor: request rise pops expected data, request fall pops expected count.
   logic       prev_req = 1'b0;
   logic [7:0] held_data = '0;
   always @(negedge clk_raw) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (tx_req && !prev_req) begin
            if (exp_data.size() == 0) begin
               checks++;
               $display("FAIL unexpected_req: got data %0h required no request", tx_data);
            end else begin
               check("req_data", {24'h0, tx_data}, {24'h0, exp_data.pop_front()});
            end
            held_data = tx_data;
         end else if (tx_req && prev_req) begin
            check("data_stable", {24'h0, tx_data}, {24'h0, held_data});
         end else if (!tx_req && prev_req) begin
            if (exp_cnt.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: got sent_cnt %0h required no completion", sent_cnt);
            end else begin
               check("sent_cnt", {16'h0, sent_cnt}, {16'h0, exp_cnt.pop_front()});
            end
         end
         prev_req = tx_req;
      end
   end

   task automatic press(input int hold_cyc);
      @(posedge clk_raw); #1 next_raw = 1'b1;
      repeat (hold_cyc) @(posedge clk_raw);
      #1 next_raw = 1'b0;
      repeat (24) @(posedge clk_raw);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_data.size() != 0 || exp_cnt.size() != 0) && n < 2000) begin
         @(posedge clk_raw); #2;
         n++;
      end
      if (n >= 2000) fail_now(name);
   endtask

   task automatic wait_data_left(input int left, input string name);
      int n;
      n = 0;
      while (exp_data.size() > left && n < 2000) begin
         @(posedge clk_raw); #2;
         n++;
      end
      if (n >= 2000) fail_now(name);
   endtask

   initial begin
      int ticks;
      int n;
      // Reset state
      #23;
      check("rst_tx_req", {31'h0, tx_req}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data}, 32'h41);
      check("rst_sent_cnt", {16'h0, sent_cnt}, 32'h0);
      check("rst_tick", {31'h0, tick}, 32'h0);

      // First handshake after release: request on tick 2, count 1
      exp_data.push_back(8'h41); exp_cnt.push_back(16'd1);
      @(posedge clk_raw); #3 rst_n = 1'b1;
      ticks = 0; n = 0;
      while (n < 200) begin
         @(negedge clk_raw);
         if (tx_req) break;
         if (tick) ticks++;
         n++;
      end
      if (n >= 200) fail_now("first_req_timeout");
      check("first_req_tick", ticks, 2);
      wait_drain("first_handshake");
      repeat (40) @(posedge clk_raw);

      // One long press -> exactly one advance
      exp_data.push_back(8'h42); exp_cnt.push_back(16'd2);
      press(200);
      wait_drain("long_press");
      repeat (40) @(posedge clk_raw);

      // Ack stuck high: no new request even with auto_en
      ack_mode = 1;
      exp_data.push_back(8'h43); exp_cnt.push_back(16'd3);
      press(24);
      wait_drain("ack_high_press");
      #1 auto_en = 1'b1;
      repeat (40) @(posedge clk_raw);
      #2 check("ack_high_no_req", {31'h0, tx_req}, 32'h0);

      // Release ack: auto run through the wrap 44,45,41
      exp_data.push_back(8'h44); exp_cnt.push_back(16'd4);
      exp_data.push_back(8'h45); exp_cnt.push_back(16'd5);
      exp_data.push_back(8'h41); exp_cnt.push_back(16'd6);
      ack_mode = 0;
      wait_data_left(0, "auto_run");
      auto_en = 1'b0;
      wait_drain("auto_stop");
      repeat (60) @(posedge clk_raw);

      // Presses during WAIT_ACK collapse into one pending advance
      exp_data.push_back(8'h42); exp_cnt.push_back(16'd7);
      exp_data.push_back(8'h43); exp_cnt.push_back(16'd8);
      ack_mode = 2;
      press(24);
      wait_data_left(1, "pend_first_req");
      press(24);
      press(24);
      ack_mode = 0;
      wait_drain("pend_drain");
      repeat (60) @(posedge clk_raw);
      #2 check("pend_final_data", {24'h0, tx_data}, 32'h43);

      // Reach 45 with request held, then reset mid-handshake
      exp_data.push_back(8'h44); exp_cnt.push_back(16'd9);
      press(24);
      wait_drain("to_44");
      ack_mode = 2;
      exp_data.push_back(8'h45);
      press(24);
      wait_data_left(0, "to_45");
      repeat (8) @(posedge clk_raw);
      #2 check("pre_rst_req", {31'h0, tx_req}, 32'h1);
      check("pre_rst_data", {24'h0, tx_data}, 32'h45);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'h0, tx_req}, 32'h0);
      check("mid_rst_data", {24'h0, tx_data}, 32'h41);
      check("mid_rst_cnt", {16'h0, sent_cnt}, 32'h0);
      check("mid_rst_tick", {31'h0, tick}, 32'h0);
      repeat (3) @(posedge clk_raw);
      ack_mode = 0;
      exp_data.push_back(8'h41); exp_cnt.push_back(16'd1);
      #3 rst_n = 1'b1;
      wait_drain("restart");
      repeat (40) @(posedge clk_raw);
      #2 check("restart_data", {24'h0, tx_data}, 32'h41);
      check("restart_cnt", {16'h0, sent_cnt}, 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

endmodule
